// File: rtl/uart_receiver.sv
// -----------------------------------------------------------------------------
// uart_receiver
//   Receive side of the 8N1 UART link. The asynchronous serial line is brought
//   into the clk domain through a two-flop synchroniser. The start bit is
//   validated at its midpoint. Eight data bits (LSB first) and the stop bit are
//   then sampled at their bit centres. A good frame updates data with a
//   one-cycle done pulse. A stop bit sampled low gives a one-cycle frame_error
//   pulse instead.
//
// Parameters
//   baud_rate        serial bit rate in bits/s
//   clock_frequency  clk frequency in Hz
//   (clk_per_bit = clock_frequency / baud_rate must be >= 4 and < 65536)
//
// Ports
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   rx           in   serial line, idles high, asynchronous to clk
//   data[7:0]    out  last correctly framed byte
//   done         out  one-cycle pulse, data has just been updated
//   frame_error  out  one-cycle pulse, stop bit was sampled low
//   busy         out  high whenever the receiver is not idle
// -----------------------------------------------------------------------------
module uart_receiver #(
  parameter int baud_rate       = 115200,
  parameter int clock_frequency = 100000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       done,
  output logic       frame_error,
  output logic       busy
);

  localparam int          clk_per_bit = clock_frequency / baud_rate;
  localparam logic [15:0] BIT_LAST    = 16'(clk_per_bit - 1);
  localparam logic [15:0] HALF_LAST   = 16'(clk_per_bit / 2 - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic        r_rx_meta;
  logic        r_rx_s;
  logic [15:0] r_t_clk;
  logic [2:0]  r_bit_idx;
  logic [7:0]  r_shift;
  logic [7:0]  r_data;
  logic        r_done;
  logic        r_frame_error;
  logic        r_armed;

  logic        w_timer_hit;
  logic        w_busy;
  logic        w_shift_en;
  logic        w_done_set;
  logic        w_ferr_set;

  // Synchroniser. It resets to the idle level so that reset release does not
  // look like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  // The START state waits only half a bit, so its sample lands at the centre
  // of the start bit. All later states wait whole bits from that point.
  assign w_timer_hit = (r_state == S_START) ? (r_t_clk == HALF_LAST)
                                            : (r_t_clk == BIT_LAST);

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM: next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (r_armed && !r_rx_s) w_state_next = S_START;
      end
      S_START: begin
        if (w_timer_hit) w_state_next = r_rx_s ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (w_timer_hit && (r_bit_idx == 3'd7)) w_state_next = S_STOP;
      end
      S_STOP: begin
        // Leave at the stop-bit centre so a following start bit is not missed.
        if (w_timer_hit) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // FSM: output logic
  always_comb begin
    w_busy     = (r_state != S_IDLE);
    w_shift_en = (r_state == S_DATA) && w_timer_hit;
    w_done_set = (r_state == S_STOP) && w_timer_hit && r_rx_s;
    w_ferr_set = (r_state == S_STOP) && w_timer_hit && !r_rx_s;
  end

  // Bit timer. It restarts on every state change and at each bit boundary,
  // and it is held at zero while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_t_clk <= 16'd0;
    end else if ((r_state == S_IDLE) || (w_state_next != r_state) || w_timer_hit) begin
      r_t_clk <= 16'd0;
    end else begin
      r_t_clk <= r_t_clk + 16'd1;
    end
  end

  // Data path. Each sample enters at bit 7 and moves right, so the first bit
  // received ends up in bit 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_idx     <= 3'd0;
      r_shift       <= 8'h00;
      r_data        <= 8'h00;
      r_done        <= 1'b0;
      r_frame_error <= 1'b0;
      r_armed       <= 1'b0;
    end else begin
      if (r_state == S_IDLE) begin
        r_bit_idx <= 3'd0;
      end else if (w_shift_en) begin
        r_bit_idx <= r_bit_idx + 3'd1;
      end

      if (w_shift_en) begin
        r_shift <= {r_rx_s, r_shift[7:1]};
      end

      if (w_done_set) begin
        r_data <= r_shift;
      end

      r_done        <= w_done_set;
      r_frame_error <= w_ferr_set;

      // A frame error disarms the receiver. A held-low line (break) therefore
      // reports once and is not re-detected until the line has been high again.
      if (w_ferr_set) begin
        r_armed <= 1'b0;
      end else if (r_rx_s) begin
        r_armed <= 1'b1;
      end
    end
  end

  assign data        = r_data;
  assign done        = r_done;
  assign frame_error = r_frame_error;
  assign busy        = w_busy;

endmodule

// File: tb/tb_uart_receiver.sv
module tb_uart_receiver;

  localparam int CPB     = 16;
  localparam int LAT_NOM = 2 + 9 * CPB + CPB / 2;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx    = 1'b1;
  logic [7:0] data;
  logic       done;
  logic       frame_error;
  logic       busy;

  uart_receiver #(
    .baud_rate      (1000000),
    .clock_frequency(16000000)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .data       (data),
    .done       (done),
    .frame_error(frame_error),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_assert = 0;
  int n_fail   = 0;

  // kind is the expected {done, frame_error} pattern at the pulse.
  typedef struct {
    logic [1:0]  kind;
    logic [7:0]  data;
    int unsigned t_start;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  last_good = 8'h00;
  logic        prev_done = 1'b0;
  logic        prev_ferr = 1'b0;
  exp_t        mon_e;
  int unsigned mon_lat;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Scoreboard: every done / frame_error pulse is matched against the oldest
  // expectation.
  always @(negedge clk) begin
    if (rst_n && (done || frame_error)) begin
      check("pulse_exclusive", 32'(done & frame_error), 32'd0);
      check("pulse_width", 32'((done & prev_done) | (frame_error & prev_ferr)), 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {30'd0, done, frame_error}, 32'd0);
      end else begin
        mon_e   = exp_q.pop_front();
        mon_lat = cyc - mon_e.t_start;
        $display("pulse done=%0b frame_error=%0b data=%02h latency=%0d", done, frame_error, data, mon_lat);
        check("pulse_kind", {30'd0, done, frame_error}, {30'd0, mon_e.kind});
        check("data_at_pulse", {24'd0, data}, {24'd0, mon_e.data});
        check("latency_window", 32'((mon_lat >= LAT_NOM - 1) && (mon_lat <= LAT_NOM + 1)), 32'd1);
      end
    end
    prev_done <= done;
    prev_ferr <= frame_error;
  end

  // Drives one frame starting on a falling clock edge and records the expected
  // outcome.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    exp_t e;
    if (stop_bit) begin
      e.kind    = 2'b10;
      e.data    = b;
      last_good = b;
    end else begin
      e.kind = 2'b01;
      e.data = last_good;
    end
    e.t_start = cyc + 1;
    exp_q.push_back(e);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_bit;
    repeat (CPB) @(negedge clk);
  endtask

  initial begin
    exp_t e;
    logic [7:0] abort_byte;

    // Reset
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_data", {24'd0, data}, 32'h00);
    check("reset_done", 32'(done), 32'd0);
    check("reset_ferr", 32'(frame_error), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_pending", 32'(exp_q.size()), 32'd0);

    // Single byte
    send_frame(8'hA5, 1'b1);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    check("single_pending", 32'(exp_q.size()), 32'd0);
    check("single_data", {24'd0, data}, 32'hA5);
    check("single_busy", 32'(busy), 32'd0);

    // Back-to-back frames with no idle gap
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h3C, 1'b1);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    check("b2b_pending", 32'(exp_q.size()), 32'd0);
    check("b2b_data", {24'd0, data}, 32'h3C);

    // Short glitch is rejected at the start-bit centre
    rx = 1'b0;
    repeat (5) @(negedge clk);
    rx = 1'b1;
    check("glitch_busy_high", 32'(busy), 32'd1);
    repeat (20) @(negedge clk);
    check("glitch_busy_low", 32'(busy), 32'd0);
    check("glitch_data", {24'd0, data}, 32'h3C);

    // Framing error: stop bit low
    send_frame(8'h55, 1'b0);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    check("ferr_pending", 32'(exp_q.size()), 32'd0);
    check("ferr_data_hold", {24'd0, data}, 32'h3C);

    // Break: one frame error only, then a valid frame
    e.kind    = 2'b01;
    e.data    = last_good;
    e.t_start = cyc + 1;
    exp_q.push_back(e);
    rx = 1'b0;
    repeat (400) @(negedge clk);
    check("break_pending", 32'(exp_q.size()), 32'd0);
    check("break_busy", 32'(busy), 32'd0);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    send_frame(8'h81, 1'b1);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    check("after_break_pending", 32'(exp_q.size()), 32'd0);
    check("after_break_data", {24'd0, data}, 32'h81);

    // Reset during bit 4 of 0x99 aborts the frame silently
    abort_byte = 8'h99;
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = abort_byte[i];
      repeat (CPB) @(negedge clk);
    end
    rx = abort_byte[4];
    repeat (CPB / 2) @(negedge clk);
    check("abort_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_reset_data", {24'd0, data}, 32'h00);
    check("abort_reset_busy", 32'(busy), 32'd0);
    rst_n     = 1'b1;
    last_good = 8'h00;
    repeat (40) @(negedge clk);
    check("abort_pending", 32'(exp_q.size()), 32'd0);
    check("abort_data", {24'd0, data}, 32'h00);
    send_frame(8'h12, 1'b1);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    check("after_abort_pending", 32'(exp_q.size()), 32'd0);
    check("after_abort_data", {24'd0, data}, 32'h12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- Receive side of the team's 8N1 UART link; companion to the existing transmitter and uses the same baud/clock parameterisation.
- Synchronises the asynchronous serial line and validates the start bit at its midpoint.
- Samples 8 data bits LSB-first, then the stop bit, each at bit centre.
- Presents the byte with a one-cycle done pulse, or flags a framing error.

Parameters:
- baud_rate, 115200, serial bit rate in bits/s.
- clock_frequency, 100000000, clk frequency in Hz.
- clk_per_bit: localparam = clock_frequency/baud_rate, integer division. Must be >= 4 and < 65536; the bit-timer counter is 16 bits.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- rx  input  1  serial line; idles high; asynchronous to clk.
- data  output  8  last correctly framed byte; holds until the next good frame.
- done  output  1  one-cycle pulse: data has just been updated.
- frame_error  output  1  one-cycle pulse: stop bit was sampled as 0.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset: rst_n low forces state=IDLE, data=8'h00, done=0, frame_error=0, busy=0, counters=0, shift register=0. The synchroniser flops reset to 1.
- Reset asserted mid-frame aborts the frame: no done or frame_error pulse, and data is unchanged from its reset value.
- Synchroniser: rx passes through 2 flops to give rx_s. All decisions use rx_s, which adds 2 cycles of latency.
- Bit timer: t_clk counts 0..limit. It reloads to 0 on every state entry.

States:
- IDLE: busy=0.
  - If armed and rx_s==0: go to START.
  - armed is set while rx_s==1 and cleared on a frame error. The receiver therefore needs the line to return high before it will accept another start bit.
- START: count to clk_per_bit/2 - 1, then sample rx_s.
  - rx_s==0: go to DATA with bit_idx=0.
  - rx_s==1: glitch; return to IDLE with no pulses.
- DATA: count to clk_per_bit - 1, then sample rx_s.
  - Shift the sample into shift[7] and shift right (LSB-first assembly).
  - bit_idx increments; after bit_idx 7 go to STOP.
- STOP: count to clk_per_bit - 1, then sample rx_s.
  - 1: data <= shift and done=1 for exactly one cycle.
  - 0: frame_error=1 for one cycle, data unchanged, armed cleared.
  - Either way, return to IDLE in the same cycle. Leaving at the stop-bit centre lets back-to-back frames be received with no idle gap.

Timing and pulse rules:
- Latency: done asserts 2 + 9*clk_per_bit + clk_per_bit/2 cycles after the first clk edge that samples rx low, ±1 cycle.
- done and frame_error are mutually exclusive and never assert together. Neither asserts outside the STOP-exit cycle.
- A new start edge seen in IDLE on the cycle after done is accepted normally.
- rx low for longer than one frame (break): reports frame_error once with data=0 captured internally, and does not re-trigger until rx_s returns high.

Test Plan:
Common setup: baud_rate=1000000, clock_frequency=16000000, so clk_per_bit=16.
- Reset: rst_n low for 3 cycles, rx=1 -> data=8'h00, done=0, frame_error=0, busy=0. Hold idle 100 cycles -> no pulses.
- Single byte: drive 0xA5 (line sequence 0,1,0,1,0,0,1,0,1,1; 16 cycles per bit) -> done pulses exactly once, width 1, at 154±1 cycles after the start edge. data=8'hA5. frame_error stays 0.
- Back-to-back: 0x00, 0xFF and 0x3C with zero idle between frames -> three done pulses spaced 160±1 cycles apart. data reads 00, FF, 3C at each pulse.
- Glitch and framing:
  - rx low for 5 cycles, then high -> busy returns to 0 without done.
  - 0x55 sent with stop bit 0, then line high -> frame_error pulses once and data keeps its previous value.
- Break and abort:
  - rx held low for 400 cycles -> exactly one frame_error. A following valid 0x81 frame after rx has been high -> done with data=8'h81.
  - rst_n pulsed low during bit 4 of 0x99 -> no pulses and data=8'h00. The next full frame, 0x12, is received correctly.
